// File: rtl/drop_spawner_pkg.sv
// Shared types, constants and helpers for the falling-character spawner.
package drop_spawner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PICK  = 2'd1,
    ST_DRAW  = 2'd2,
    ST_OFFER = 2'd3
  } state_e;

  localparam logic [7:0]  ASCII_A      = 8'h41;
  localparam logic [4:0]  ALPHABET_LEN = 5'd26;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef struct packed {
    logic [7:0] ch;
    logic [3:0] speed;
    logic [9:0] y;
  } draw_t;

  // One Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  // Map raw random bits onto a legal record. Each range reduction needs at
  // most one subtraction because the raw range is below twice the target.
  function automatic draw_t map_draw(input logic [4:0]  ch_raw,
                                     input logic [3:0]  spd_raw,
                                     input logic [9:0]  y_raw,
                                     input logic [10:0] y_range);
    draw_t d;
    if (ch_raw >= ALPHABET_LEN) d.ch = ASCII_A + {3'b000, ch_raw - ALPHABET_LEN};
    else                        d.ch = ASCII_A + {3'b000, ch_raw};
    d.speed = (spd_raw == 4'd0) ? 4'd1 : spd_raw;
    if ({1'b0, y_raw} >= y_range) d.y = 10'({1'b0, y_raw} - y_range);
    else                          d.y = y_raw;
    return d;
  endfunction

endpackage

// File: rtl/drop_spawner_if.sv
// Spawn-record handshake, slot release channel and occupancy mask.
interface drop_spawner_if #(
  parameter int N_SLOTS = 8
);
  logic               spawn_valid;
  logic               spawn_ready;
  logic [7:0]         ch;
  logic [3:0]         speed;
  logic [8:0]         x;
  logic [9:0]         y;
  logic [3:0]         slot;
  logic               release_valid;
  logic [3:0]         release_slot;
  logic [N_SLOTS-1:0] busy_mask;

  // Spawner side.
  modport master (
    output spawn_valid, ch, speed, x, y, slot, busy_mask,
    input  spawn_ready, release_valid, release_slot
  );

  // Consumer side.
  modport slave (
    input  spawn_valid, ch, speed, x, y, slot, busy_mask,
    output spawn_ready, release_valid, release_slot
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free running, reloaded with its seed on reset.
module lfsr16
  import drop_spawner_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  // Next value is one shift of the register.
  always_comb begin
    value_d = lfsr_next(value_q);
  end

  // State register with synchronous reset to the seed.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) value_q <= seed;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/drop_spawner.sv
// Periodically picks a free slot, draws a random character/speed/column and
// offers the record to a consumer; tracks slot occupancy.
module drop_spawner
  import drop_spawner_pkg::*;
#(
  parameter int          N_SLOTS      = 8,
  parameter int          Y_RANGE      = 640,
  parameter int          SPAWN_PERIOD = 1024,
  parameter logic [15:0] SEED_CH      = 16'h0001,
  parameter logic [15:0] SEED_SPD     = 16'h013B,
  parameter logic [15:0] SEED_Y       = 16'h0140
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  drop_spawner_if.master bus
);

  localparam int                  TIMER_W      = $clog2(SPAWN_PERIOD);
  localparam logic [TIMER_W-1:0]  TIMER_RELOAD = TIMER_W'(SPAWN_PERIOD - 1);
  localparam logic [10:0]         Y_RANGE_L    = 11'(Y_RANGE);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [N_SLOTS-1:0] busy_q,  busy_d;
  logic [3:0]         slot_q,  slot_d;
  draw_t              rec_q,   rec_d;

  logic [15:0] lfsr_ch, lfsr_spd, lfsr_y;
  logic        free_any;
  logic [3:0]  free_idx;
  logic        handshake;

  lfsr16 u_lfsr_ch  (.clk(clk), .rst(rst), .seed(SEED_CH),  .value(lfsr_ch));
  lfsr16 u_lfsr_spd (.clk(clk), .rst(rst), .seed(SEED_SPD), .value(lfsr_spd));
  lfsr16 u_lfsr_y   (.clk(clk), .rst(rst), .seed(SEED_Y),   .value(lfsr_y));

  // Only the low bits of each generator feed the record.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^{lfsr_ch[15:5], lfsr_spd[15:4], lfsr_y[15:10]};

  assign handshake = (state_q == ST_OFFER) && bus.spawn_ready;

  // Lowest-index free slot (descending scan so the lowest wins).
  always_comb begin
    free_any = 1'b0;
    free_idx = 4'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any = 1'b1;
        free_idx = 4'(i);
      end
    end
  end

  // Occupancy: release clears, accepted record sets; the offered slot is
  // still free until accepted, so releasing it meanwhile changes nothing.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (bus.release_valid && (bus.release_slot == 4'(i))) busy_d[i] = 1'b0;
      if (handshake && (slot_q == 4'(i)))                   busy_d[i] = 1'b1;
    end
  end

  // FSM next state, spawn timer and record capture.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    slot_d  = slot_q;
    rec_d   = rec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          if (timer_q == '0) state_d = ST_PICK;
          else               timer_d = timer_q - 1'b1;
        end
      end
      ST_PICK: begin
        if (free_any) begin
          slot_d  = free_idx;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        rec_d   = map_draw(lfsr_ch[4:0], lfsr_spd[3:0], lfsr_y[9:0], Y_RANGE_L);
        state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (bus.spawn_ready) begin
          timer_d = TIMER_RELOAD;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset wins over any handshake or release.
  // NOTE: only control/record flops exist here, so all of them are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= TIMER_RELOAD;
      busy_q  <= '0;
      slot_q  <= 4'd0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      slot_q  <= slot_d;
      rec_q   <= rec_d;
    end
  end

  assign bus.spawn_valid = (state_q == ST_OFFER);
  assign bus.ch          = rec_q.ch;
  assign bus.speed       = rec_q.speed;
  assign bus.x           = 9'd0;
  assign bus.y           = rec_q.y;
  assign bus.slot        = slot_q;
  assign bus.busy_mask   = busy_q;

endmodule

// File: tb/tb_drop_spawner.sv
// Directed bench for drop_spawner plus a long randomised consumer run.
module tb_drop_spawner;

  // Reference LFSR step, written from the tap list 16,14,13,11.
  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Inverse step, used to pick seeds that land on chosen values.
  function automatic logic [15:0] ref_back(input logic [15:0] v, input int n);
    logic [15:0] p;
    p = v;
    for (int i = 0; i < n; i++) p = {p[0] ^ p[14] ^ p[13] ^ p[11], p[15:1]};
    return p;
  endfunction

  function automatic logic [7:0] exp_ch(input logic [15:0] v);
    int r;
    r = int'(v[4:0]);
    if (r >= 26) r = r - 26;
    return 8'(65 + r);
  endfunction

  function automatic logic [3:0] exp_speed(input logic [15:0] v);
    return (v[3:0] == 4'd0) ? 4'd1 : v[3:0];
  endfunction

  function automatic logic [9:0] exp_y(input logic [15:0] v);
    int r;
    r = int'(v[9:0]);
    if (r >= 640) r = r - 640;
    return 10'(r);
  endfunction

  // First record of the edge instance is drawn 5 steps after reset.
  localparam logic [15:0] EDGE_SEED_CH  = ref_back(16'h001F, 5);
  localparam logic [15:0] EDGE_SEED_SPD = ref_back(16'h0010, 5);
  localparam logic [15:0] EDGE_SEED_Y   = ref_back(16'h03FF, 5);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  drop_spawner_if #(.N_SLOTS(8)) bus ();
  drop_spawner_if #(.N_SLOTS(8)) ebus ();

  drop_spawner #(.SPAWN_PERIOD(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus)
  );

  drop_spawner #(
    .SPAWN_PERIOD(4),
    .SEED_CH(EDGE_SEED_CH), .SEED_SPD(EDGE_SEED_SPD), .SEED_Y(EDGE_SEED_Y)
  ) u_dut_edge (
    .clk(clk), .rst(rst), .en(1'b1), .bus(ebus)
  );

  always #5 clk = ~clk;

  // Independent LFSR and occupancy model of the main instance.
  logic [15:0] m_ch, m_spd, m_y, p_ch, p_spd, p_y;
  logic [7:0]  mask_m;
  always @(posedge clk) begin
    p_ch  <= m_ch;
    p_spd <= m_spd;
    p_y   <= m_y;
    if (rst) begin
      m_ch   <= 16'h0001;
      m_spd  <= 16'h013B;
      m_y    <= 16'h0140;
      mask_m <= 8'h00;
    end else begin
      logic [7:0] nm;
      m_ch  <= ref_step(m_ch);
      m_spd <= ref_step(m_spd);
      m_y   <= ref_step(m_y);
      nm = mask_m;
      if (bus.release_valid && bus.release_slot < 4'd8) nm[bus.release_slot[2:0]] = 1'b0;
      if (bus.spawn_valid && bus.spawn_ready)           nm[bus.slot[2:0]] = 1'b1;
      mask_m <= nm;
    end
  end

  // Capture the first record of the edge instance.
  logic       cap_done = 1'b0;
  logic [7:0] cap_ch;
  logic [3:0] cap_speed;
  logic [9:0] cap_y;
  logic [8:0] cap_x;
  logic [3:0] cap_slot;
  always @(negedge clk) begin
    if (!rst && ebus.spawn_valid && !cap_done) begin
      cap_done  = 1'b1;
      cap_ch    = ebus.ch;
      cap_speed = ebus.speed;
      cap_y     = ebus.y;
      cap_x     = ebus.x;
      cap_slot  = ebus.slot;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for spawn_valid; returns at the negedge where it is seen.
  task automatic wait_valid(input string tag, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.spawn_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  // Compare the offered record with the model's values from the DRAW cycle.
  task automatic check_record(input string tag, input logic [3:0] exp_slot);
    check({tag, "_slot"},  32'(bus.slot),  32'(exp_slot));
    check({tag, "_ch"},    32'(bus.ch),    32'(exp_ch(p_ch)));
    check({tag, "_speed"}, 32'(bus.speed), 32'(exp_speed(p_spd)));
    check({tag, "_y"},     32'(bus.y),     32'(exp_y(p_y)));
    check({tag, "_x"},     32'(bus.x),     32'd0);
  endtask

  initial begin
    logic [7:0] hold_ch;
    logic [3:0] hold_speed;
    logic [9:0] hold_y;
    int         n_valid;
    logic       prev_valid;

    bus.spawn_ready    = 1'b0;
    bus.release_valid  = 1'b0;
    bus.release_slot   = 4'd0;
    ebus.spawn_ready   = 1'b1;
    ebus.release_valid = 1'b0;
    ebus.release_slot  = 4'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.spawn_valid), 32'd0);
    check("rst_mask",  32'(bus.busy_mask),   32'h00);
    check("rst_ch",    32'(bus.ch),          32'd0);
    check("rst_speed", 32'(bus.speed),       32'd0);
    check("rst_y",     32'(bus.y),           32'd0);
    check("rst_slot",  32'(bus.slot),        32'd0);
    check("rst_x",     32'(bus.x),           32'd0);

    // First spawn arrives 6 cycles after reset release.
    rst = 1'b0;
    en = 1'b1;
    bus.spawn_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("first_early_%0d", i), 32'(bus.spawn_valid), 32'd0);
    end
    @(negedge clk);
    check("first_valid", 32'(bus.spawn_valid), 32'd1);
    check_record("first", 4'd0);
    @(negedge clk);
    check("first_drop", 32'(bus.spawn_valid), 32'd0);
    check("first_mask", 32'(bus.busy_mask),   32'h01);

    // Stalled consumer: record held stable; en low does not abort OFFER.
    bus.spawn_ready = 1'b0;
    wait_valid("stall", 20);
    check_record("stall", 4'd1);
    hold_ch    = exp_ch(p_ch);
    hold_speed = exp_speed(p_spd);
    hold_y     = exp_y(p_y);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.spawn_valid), 32'd1);
      check("stall_ch",    32'(bus.ch),          32'(hold_ch));
      check("stall_speed", 32'(bus.speed),       32'(hold_speed));
      check("stall_y",     32'(bus.y),           32'(hold_y));
      check("stall_slot",  32'(bus.slot),        32'd1);
      check("stall_mask",  32'(bus.busy_mask),   32'h01);
    end
    en = 1'b1;
    bus.spawn_ready = 1'b1;
    @(negedge clk);
    check("stall_drop", 32'(bus.spawn_valid), 32'd0);
    check("stall_mask_after", 32'(bus.busy_mask), 32'h03);

    // Fill remaining slots in order.
    for (int k = 2; k < 8; k++) begin
      wait_valid($sformatf("fill_%0d", k), 20);
      check_record($sformatf("fill_%0d", k), 4'(k));
      @(negedge clk);
    end
    check("full_mask", 32'(bus.busy_mask), 32'hFF);

    // All slots busy: FSM waits in PICK.
    n_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.spawn_valid) n_valid++;
    end
    check("full_no_spawn", 32'(n_valid), 32'd0);

    // Out-of-range release is ignored.
    bus.release_valid = 1'b1;
    bus.release_slot  = 4'd9;
    @(negedge clk);
    bus.release_valid = 1'b0;
    check("rel_oob_mask", 32'(bus.busy_mask), 32'hFF);
    check("rel_oob_valid", 32'(bus.spawn_valid), 32'd0);

    // Freeing slot 5 lets the stalled PICK proceed with slot 5.
    bus.spawn_ready   = 1'b0;
    bus.release_valid = 1'b1;
    bus.release_slot  = 4'd5;
    @(negedge clk);
    bus.release_valid = 1'b0;
    check("rel5_mask", 32'(bus.busy_mask), 32'hDF);
    wait_valid("rel5", 10);
    check_record("rel5", 4'd5);

    // Accept slot 5 with the timer frozen, then free slots 7..2.
    en = 1'b0;
    bus.spawn_ready = 1'b1;
    @(negedge clk);
    bus.spawn_ready = 1'b0;
    check("acc5_mask", 32'(bus.busy_mask), 32'hFF);
    for (int s = 7; s >= 2; s--) begin
      bus.release_valid = 1'b1;
      bus.release_slot  = 4'(s);
      @(negedge clk);
    end
    bus.release_valid = 1'b0;
    check("freed_mask", 32'(bus.busy_mask), 32'h03);
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.spawn_valid) n_valid++;
    end
    check("en_low_no_spawn", 32'(n_valid), 32'd0);

    // Offer slot 2, free slot 1 during OFFER, then release of slot 2 is a no-op.
    en = 1'b1;
    wait_valid("slot2", 20);
    check_record("slot2", 4'd2);
    bus.release_valid = 1'b1;
    bus.release_slot  = 4'd1;
    @(negedge clk);
    check("rel1_mask", 32'(bus.busy_mask), 32'h01);
    bus.release_slot  = 4'd2;
    @(negedge clk);
    check("rel_offered_mask",  32'(bus.busy_mask),   32'h01);
    check("rel_offered_valid", 32'(bus.spawn_valid), 32'd1);

    // Handshake on slot 2 together with release of slot 0.
    bus.spawn_ready  = 1'b1;
    bus.release_slot = 4'd0;
    @(negedge clk);
    bus.release_valid = 1'b0;
    bus.spawn_ready   = 1'b0;
    check("hs_rel_mask",  32'(bus.busy_mask),   32'h04);
    check("hs_rel_valid", 32'(bus.spawn_valid), 32'd0);

    // Reset during OFFER dominates handshake and release.
    wait_valid("pre_rst", 20);
    check("pre_rst_slot", 32'(bus.slot), 32'd0);
    rst = 1'b1;
    bus.spawn_ready   = 1'b1;
    bus.release_valid = 1'b1;
    bus.release_slot  = 4'd2;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.spawn_valid), 32'd0);
    check("mid_rst_mask",  32'(bus.busy_mask),   32'h00);
    check("mid_rst_slot",  32'(bus.slot),        32'd0);
    rst = 1'b0;
    bus.release_valid = 1'b0;

    // Long run with a random consumer.
    prev_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (bus.spawn_valid && !prev_valid) begin
        check("rnd_ch_range", 32'(bus.ch >= 8'h41 && bus.ch <= 8'h5A), 32'd1);
        check("rnd_speed_nz", 32'(bus.speed != 4'd0), 32'd1);
        check("rnd_y_range",  32'(bus.y < 10'd640), 32'd1);
        check("rnd_ch",       32'(bus.ch),    32'(exp_ch(p_ch)));
        check("rnd_speed",    32'(bus.speed), 32'(exp_speed(p_spd)));
        check("rnd_y",        32'(bus.y),     32'(exp_y(p_y)));
        check("rnd_slot_free", 32'(mask_m[bus.slot[2:0]]), 32'd0);
        check("rnd_mask",     32'(bus.busy_mask), 32'(mask_m));
      end
      prev_valid = bus.spawn_valid;
      bus.spawn_ready   = 1'($urandom_range(0, 1));
      bus.release_valid = 1'($urandom_range(0, 1));
      bus.release_slot  = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    check("rnd_final_mask", 32'(bus.busy_mask), 32'(mask_m));

    // Range-reduction corners on the edge instance's first record.
    check("edge_seen",  32'(cap_done),  32'd1);
    check("edge_ch",    32'(cap_ch),    32'h46);
    check("edge_speed", 32'(cap_speed), 32'd1);
    check("edge_y",     32'(cap_y),     32'd383);
    check("edge_x",     32'(cap_x),     32'd0);
    check("edge_slot",  32'(cap_slot),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
